// File: rtl/conv_window_sequencer_pkg.sv
// Shared types, layer constants and width helpers for the conv window sequencer.
package conv_window_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE} seq_state_t;

  // Default layer geometry for the two conv layers that reuse this block
  localparam int CONV1_IMG_W = 28;
  localparam int CONV1_IMG_H = 28;
  localparam int CONV1_K     = 5;
  localparam int CONV2_IMG_W = 12;
  localparam int CONV2_IMG_H = 12;
  localparam int CONV2_K     = 5;
  localparam int DEF_MAC_LAT = 2;

  // Bit width needed to index n items; never below 1 so degenerate sizes still elaborate
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Control/address bus between the sequencer (master) and the layer controller,
// buffers and MAC (slave side).
interface conv_window_sequencer_if
  import conv_window_sequencer_pkg::*;
#(
  parameter int IMG_W = CONV1_IMG_W,
  parameter int IMG_H = CONV1_IMG_H,
  parameter int K     = CONV1_K
) ();

  localparam int OW   = IMG_W - K + 1;
  localparam int OH   = IMG_H - K + 1;
  localparam int IA_W = cw(IMG_W * IMG_H);
  localparam int KA_W = cw(K * K);
  localparam int OA_W = cw(OW * OH);

  logic            start;
  logic            busy;
  logic            done;
  logic            img_rd;
  logic [IA_W-1:0] img_addr;
  logic            kern_rd;
  logic [KA_W-1:0] kern_addr;
  logic            mac_clr;
  logic            mac_acc;
  logic            out_we;
  logic            out_ready;
  logic [OA_W-1:0] out_addr;

  modport master (
    input  start, out_ready,
    output busy, done, img_rd, img_addr, kern_rd, kern_addr,
           mac_clr, mac_acc, out_we, out_addr
  );

  modport slave (
    output start, out_ready,
    input  busy, done, img_rd, img_addr, kern_rd, kern_addr,
           mac_clr, mac_acc, out_we, out_addr
  );

endinterface

// File: rtl/conv_window_sequencer_counter.sv
// Nested window counters: kx innermost, then ky, per output pixel ox then oy.
// A pixel step also rewinds the window so each pixel starts at tap 0.
module conv_window_counter
  import conv_window_sequencer_pkg::*;
#(
  parameter int IMG_W = CONV1_IMG_W,
  parameter int IMG_H = CONV1_IMG_H,
  parameter int K     = CONV1_K
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr_i,
  input  logic                          tap_step_i,
  input  logic                          pix_step_i,
  output logic [cw(K)-1:0]              kx_o,
  output logic [cw(K)-1:0]              ky_o,
  output logic [cw(IMG_W-K+1)-1:0]      ox_o,
  output logic [cw(IMG_H-K+1)-1:0]      oy_o,
  output logic                          last_tap_o,
  output logic                          last_pixel_o
);

  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int KC_W  = cw(K);
  localparam int OXC_W = cw(OW);
  localparam int OYC_W = cw(OH);

  logic [KC_W-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [OXC_W-1:0] ox_q, ox_d;
  logic [OYC_W-1:0] oy_q, oy_d;
  logic             kx_wrap, ky_wrap, ox_wrap, oy_wrap;

  assign kx_wrap = (kx_q == KC_W'(K - 1));
  assign ky_wrap = (ky_q == KC_W'(K - 1));
  assign ox_wrap = (ox_q == OXC_W'(OW - 1));
  assign oy_wrap = (oy_q == OYC_W'(OH - 1));

  assign last_tap_o   = kx_wrap & ky_wrap;
  assign last_pixel_o = ox_wrap & oy_wrap;

  // Next counter values: clr restarts the layer, tap step walks the window, pixel step walks the map
  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clr_i) begin
      kx_d = '0;
      ky_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else begin
      if (tap_step_i) begin
        if (kx_wrap) begin
          kx_d = '0;
          ky_d = ky_wrap ? '0 : ky_q + 1'b1;
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      if (pix_step_i) begin
        kx_d = '0;
        ky_d = '0;
        if (ox_wrap) begin
          ox_d = '0;
          oy_d = oy_wrap ? '0 : oy_q + 1'b1;
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      kx_q <= '0;
      ky_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  assign kx_o = kx_q;
  assign ky_o = ky_q;
  assign ox_o = ox_q;
  assign oy_o = oy_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Valid-mode convolution sequencer: per output pixel clear the MAC, stream the
// K*K image/kernel reads, let the MAC pipeline drain, then hold the result
// write until the result buffer accepts it. Addresses and strobes only.
module conv_window_sequencer
  import conv_window_sequencer_pkg::*;
#(
  parameter int IMG_W   = CONV1_IMG_W,
  parameter int IMG_H   = CONV1_IMG_H,
  parameter int K       = CONV1_K,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input logic                    clk,
  input logic                    reset,
  conv_window_sequencer_if.master bus
);

  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int KC_W  = cw(K);
  localparam int OXC_W = cw(OW);
  localparam int OYC_W = cw(OH);
  localparam int IA_W  = cw(IMG_W * IMG_H);
  localparam int KA_W  = cw(K * K);
  localparam int OA_W  = cw(OW * OH);
  localparam int DRN_W = cw(MAC_LAT);

  seq_state_t       state_q, state_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [MAC_LAT-1:0] acc_pipe_q;

  logic             cnt_clr, tap_step, pix_step;
  logic             last_tap, last_pixel;
  logic [KC_W-1:0]  kx, ky;
  logic [OXC_W-1:0] ox;
  logic [OYC_W-1:0] oy;
  logic             img_rd;

  conv_window_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (cnt_clr),
    .tap_step_i   (tap_step),
    .pix_step_i   (pix_step),
    .kx_o         (kx),
    .ky_o         (ky),
    .ox_o         (ox),
    .oy_o         (oy),
    .last_tap_o   (last_tap),
    .last_pixel_o (last_pixel)
  );

  // Next-state and counter strobes; start only matters in IDLE
  always_comb begin
    state_d  = state_q;
    drn_d    = '0;
    cnt_clr  = 1'b0;
    tap_step = 1'b0;
    pix_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          cnt_clr = 1'b1;
        end
      end
      CLEAR: state_d = ACCUM;
      ACCUM: begin
        tap_step = 1'b1;
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_W'(MAC_LAT - 1)) begin
          state_d = WRITE;
          drn_d   = '0;
        end
      end
      WRITE: begin
        if (bus.out_ready) begin
          pix_step = 1'b1;
          state_d  = last_pixel ? DONE : CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and drain-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
    end
  end

  assign img_rd = (state_q == ACCUM);

  // Operand-valid delay line matching the buffer-to-MAC latency; reset flushes it
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_pipe_q <= '0;
    end else begin
      acc_pipe_q[0] <= img_rd;
      for (int i = 1; i < MAC_LAT; i++) acc_pipe_q[i] <= acc_pipe_q[i-1];
    end
  end

  // Addresses are forced to zero outside the states where they carry meaning
  assign bus.img_addr  = img_rd ?
                         IA_W'((32'(oy) + 32'(ky)) * IMG_W + 32'(ox) + 32'(kx)) : '0;
  assign bus.kern_addr = img_rd ? KA_W'(32'(ky) * K + 32'(kx)) : '0;
  assign bus.out_addr  = (state_q == WRITE) ? OA_W'(32'(oy) * OW + 32'(ox)) : '0;

  assign bus.img_rd  = img_rd;
  assign bus.kern_rd = img_rd;
  assign bus.mac_clr = (state_q == CLEAR);
  assign bus.mac_acc = acc_pipe_q[MAC_LAT-1];
  assign bus.out_we  = (state_q == WRITE);
  assign bus.done    = (state_q == DONE);
  assign bus.busy    = (state_q == CLEAR) || (state_q == ACCUM) ||
                       (state_q == DRAIN) || (state_q == WRITE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer on a 6x6 map with a 3x3 kernel.
// The reference tracks (pixel, phase-within-pixel) and derives every output
// from window arithmetic; directed runs pin the reference with literals.
module tb_conv_window_sequencer;

  localparam int IMG_W = 6, IMG_H = 6, K = 3, MAC_LAT = 2;
  localparam int OW = IMG_W - K + 1, OH = IMG_H - K + 1;
  localparam int KK = K * K, NPIX = OW * OH;
  localparam int WP = 1 + KK + MAC_LAT;   // phase index of the write cycle

  logic clk = 1'b0;
  logic reset = 1'b1;

  conv_window_sequencer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) bus ();

  conv_window_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .MAC_LAT(MAC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model state
  int cyc = 0, t0 = 0;
  bit m_en = 0, m_run = 0, m_done = 0;
  int m_p = 0, m_ph = 0;

  // Capture of DUT activity for the directed literal checks
  int img_q[$], kern_q[$], oa_q[$];
  int hs_cnt, acc_cnt, acc_first, rd_first, clr_first, done_rel, rel;

  task automatic clr_logs();
    img_q.delete(); kern_q.delete(); oa_q.delete();
    hs_cnt = 0; acc_cnt = 0; acc_first = -1; rd_first = -1; clr_first = -1; done_rel = -1;
  endtask

  // Reference: advance one cycle using the inputs sampled on this edge
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_en = 1; m_run = 0; m_done = 0;
    end else if (m_run) begin
      if (m_ph < WP) m_ph++;
      else if (bus.out_ready) begin
        if (m_p == NPIX - 1) begin m_run = 0; m_done = 1; end
        else begin m_p++; m_ph = 0; end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (bus.start) begin
      m_run = 1; m_p = 0; m_ph = 0; t0 = cyc;
    end
  end

  // Compare every output against the reference each cycle, mid-cycle
  bit e_rd, e_acc, e_we;
  int tap, ox, oy, e_img, e_kern, e_oa;
  always @(negedge clk) begin
    if (m_en) begin
      e_rd   = m_run && m_ph >= 1 && m_ph <= KK;
      e_acc  = m_run && m_ph >= MAC_LAT + 1 && m_ph <= KK + MAC_LAT;
      e_we   = m_run && m_ph == WP;
      tap    = m_ph - 1;
      ox     = m_p % OW;
      oy     = m_p / OW;
      e_img  = e_rd ? (oy + tap / K) * IMG_W + ox + tap % K : 0;
      e_kern = e_rd ? tap : 0;
      e_oa   = e_we ? m_p : 0;
      chk("busy",      bus.busy,      m_run);
      chk("done",      bus.done,      m_done);
      chk("mac_clr",   bus.mac_clr,   m_run && m_ph == 0);
      chk("img_rd",    bus.img_rd,    e_rd);
      chk("kern_rd",   bus.kern_rd,   e_rd);
      chk("img_addr",  bus.img_addr,  e_img);
      chk("kern_addr", bus.kern_addr, e_kern);
      chk("mac_acc",   bus.mac_acc,   e_acc);
      chk("out_we",    bus.out_we,    e_we);
      chk("out_addr",  bus.out_addr,  e_oa);
      rel = cyc - t0 + 1;
      if (bus.img_rd) begin
        img_q.push_back(int'(bus.img_addr));
        kern_q.push_back(int'(bus.kern_addr));
        if (rd_first < 0) rd_first = rel;
      end
      if (bus.mac_acc) begin
        acc_cnt++;
        if (acc_first < 0) acc_first = rel;
      end
      if (bus.mac_clr && clr_first < 0) clr_first = rel;
      if (bus.out_we && bus.out_ready) begin
        hs_cnt++;
        oa_q.push_back(int'(bus.out_addr));
      end
      if (bus.done) done_rel = rel;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done && n < 1000) begin
      step();
      n++;
    end
    chk({nm, " done seen"}, bus.done, 1);
  endtask

  int exp9[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    clr_logs();
    step_n(3);
    reset = 1'b0;
    step();

    // Full layer, no backpressure
    clr_logs();
    run_start();
    wait_done("t1");
    step();
    chk("t1 done cycle", done_rel, 209);
    chk("t1 handshakes", hs_cnt, 16);
    chk("t1 reads", img_q.size(), 144);
    for (int i = 0; i < 9 && i < img_q.size(); i++) begin
      chk("t1 first img_addr", img_q[i], exp9[i]);
      chk("t1 first kern_addr", kern_q[i], i);
    end
    for (int i = 0; i < oa_q.size(); i++) chk("t1 out_addr order", oa_q[i], i);
    if (img_q.size() == 144) begin
      chk("t1 last window start", img_q[135], 21);
      chk("t1 last window end", img_q[143], 35);
    end
    chk("t2 mac_acc count", acc_cnt, 144);
    chk("t2 first img_rd", rd_first, 2);
    chk("t2 first mac_acc", acc_first, 4);
    chk("t2 first mac_clr", clr_first, 1);

    // Backpressure on pixel 7 write
    clr_logs();
    run_start();
    step_n(103);
    chk("t3 we at 104", bus.out_we, 1);
    chk("t3 addr at 104", bus.out_addr, 7);
    bus.out_ready = 1'b0;
    step_n(3);
    chk("t3 we held", bus.out_we, 1);
    chk("t3 addr held", bus.out_addr, 7);
    chk("t3 no read while held", bus.img_rd, 0);
    step_n(2);
    bus.out_ready = 1'b1;
    wait_done("t3");
    step();
    chk("t3 done cycle", done_rel, 214);
    chk("t3 handshakes", hs_cnt, 16);

    // Reset mid-layer
    clr_logs();
    run_start();
    step_n(49);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4 outputs after reset",
        {bus.busy, bus.done, bus.img_rd, bus.kern_rd, bus.mac_clr, bus.mac_acc, bus.out_we,
         bus.img_addr, bus.kern_addr, bus.out_addr}, 0);
    chk("t4 writes before reset", hs_cnt, 3);
    step_n(30);
    chk("t4 no writes after reset", hs_cnt, 3);
    clr_logs();
    run_start();
    wait_done("t4");
    step();
    chk("t4 restart img_addr", (img_q.size() > 0) ? img_q[0] : -1, 0);
    chk("t4 restart out_addr", (oa_q.size() > 0) ? oa_q[0] : -1, 0);
    chk("t4 restart handshakes", hs_cnt, 16);

    // Spurious starts mid-layer and on the done cycle
    clr_logs();
    run_start();
    step_n(29);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("t5");
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t5 done cycle", done_rel, 209);
    chk("t5 handshakes", hs_cnt, 16);
    chk("t5 reads", img_q.size(), 144);
    chk("t5 idle after done", bus.busy, 0);
    clr_logs();
    run_start();
    wait_done("t5 second");
    step();
    chk("t5 second handshakes", hs_cnt, 16);
    chk("t5 second done cycle", done_rel, 209);

    // start and reset together
    bus.start = 1'b1;
    reset = 1'b1;
    step();
    bus.start = 1'b0;
    reset = 1'b0;
    chk("t6 busy", bus.busy, 0);
    step();
    chk("t6 busy later", bus.busy, 0);
    chk("t6 mac_clr", bus.mac_clr, 0);

    // Random backpressure, stray starts and occasional reset
    for (int i = 0; i < 4000; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.start     = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 999) == 0);
      step();
    end
    bus.start = 1'b0;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step_n(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
